// File: rtl/weighted_round_robin.sv
`default_nettype none
// ============================================================================
// Module   : weighted_round_robin
// Purpose  : Round-robin arbiter granting each winner a weighted transfer budget.
// Revision : 1.0
// ============================================================================
module weighted_round_robin #(
  parameter int REQUEST_WIDTH = 8,
  parameter int WEIGHT_WIDTH  = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [REQUEST_WIDTH-1:0]               i_request,
  input  logic [REQUEST_WIDTH*WEIGHT_WIDTH-1:0]  i_weight,
  input  logic                                   i_ack,
  output logic                                   o_grant_valid,
  output logic [$clog2(REQUEST_WIDTH)-1:0]       o_grant,
  output logic [WEIGHT_WIDTH-1:0]                o_credit
);

  localparam int IDX_W = $clog2(REQUEST_WIDTH);
  localparam logic [IDX_W-1:0]        c_last_idx = IDX_W'(REQUEST_WIDTH - 1);
  localparam logic [WEIGHT_WIDTH-1:0] c_one      = WEIGHT_WIDTH'(1);

  logic                    valid_q,  valid_d;
  logic [IDX_W-1:0]        grant_q,  grant_d;
  logic [IDX_W-1:0]        ptr_q,    ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic                    w_release;
  logic                    w_arb;
  logic                    w_found;
  logic [IDX_W-1:0]        w_winner;
  logic [WEIGHT_WIDTH-1:0] w_weight_sel;
  int                      w_idx;

  // A dropped request releases the grant even if an ack arrives the same cycle.
  assign w_release = valid_q && ((i_ack && (credit_q == c_one)) || !i_request[grant_q]);
  assign w_arb     = !valid_q || w_release;

  // Search starts just after the last grantee, so it is considered last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = ptr_q;
    w_idx    = 0;
    for (int k = 1; k <= REQUEST_WIDTH; k++) begin
      w_idx = (int'(ptr_q) + k) % REQUEST_WIDTH;
      if (!w_found && i_request[IDX_W'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_weight_sel = '0;
    for (int i = 0; i < REQUEST_WIDTH; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_weight_sel = i_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if (w_arb) begin
      if (w_found) begin
        valid_d  = 1'b1;
        grant_d  = w_winner;
        ptr_d    = w_winner;
        // A zero weight still allows one transfer.
        credit_d = (w_weight_sel == '0) ? c_one : w_weight_sel;
      end else begin
        valid_d  = 1'b0;
        credit_d = '0;
      end
    end else if (valid_q && i_ack) begin
      credit_d = credit_q - c_one;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      grant_q  <= '0;
      ptr_q    <= c_last_idx;
      credit_q <= '0;
    end else begin
      valid_q  <= valid_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign o_grant_valid = valid_q;
  assign o_grant       = grant_q;
  assign o_credit      = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_weighted_round_robin.sv
`default_nettype none
// ============================================================================
// Module   : tb_weighted_round_robin
// Purpose  : Directed vectors plus randomized checks against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_weighted_round_robin;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [31:0] wt;
  logic        ack;
  logic        o_grant_valid;
  logic [2:0]  o_grant;
  logic [3:0]  o_credit;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_valid, m_grant, m_credit, m_ptr;

  typedef struct {
    logic        rst;
    logic [7:0]  req;
    logic [31:0] w;
    logic        ack;
    int          ev;
    int          eg;
    int          ec;
  } vec_t;

  vec_t vecs[$];

  weighted_round_robin #(.REQUEST_WIDTH(8), .WEIGHT_WIDTH(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_request     (req),
    .i_weight      (wt),
    .i_ack         (ack),
    .o_grant_valid (o_grant_valid),
    .o_grant       (o_grant),
    .o_credit      (o_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(logic r, logic [7:0] q, logic [31:0] w, logic a,
                              int v, int g, int c);
    vecs.push_back('{r, q, w, a, v, g, c});
  endfunction

  function automatic int weight_of(logic [31:0] w, int idx);
    int x;
    x = int'((w >> (idx * 4)) & 32'hF);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic bit req_bit(logic [7:0] q, int idx);
    return ((q >> idx) & 8'd1) != 8'd0;
  endfunction

  // Spec rules applied directly: release test, circular search, credit bookkeeping.
  task automatic model_clock();
    bit rel;
    int win;
    if (rst) begin
      m_valid = 0; m_grant = 0; m_credit = 0; m_ptr = 7;
    end else begin
      rel = (m_valid == 1) && ((ack && m_credit == 1) || !req_bit(req, m_grant));
      if (m_valid == 0 || rel) begin
        win = -1;
        for (int d = 1; d <= 8; d++)
          if (win < 0 && req_bit(req, (m_ptr + d) % 8)) win = (m_ptr + d) % 8;
        if (win >= 0) begin
          m_valid = 1; m_grant = win; m_ptr = win; m_credit = weight_of(wt, win);
        end else begin
          m_valid = 0; m_credit = 0;
        end
      end else if (ack) begin
        m_credit = m_credit - 1;
      end
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [7:0] q, logic [31:0] w, logic a);
    rst = r; req = q; wt = w; ack = a;
  endtask

  initial begin
    drive(1'b1, 8'h00, 32'h0, 1'b0);
    tick();
    tick();
    check("reset_valid",  int'(o_grant_valid), 0);
    check("reset_grant",  int'(o_grant), 0);
    check("reset_credit", int'(o_credit), 0);

    // Full rotation, unit weights
    add(1, 8'hFF, 32'h11111111, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) add(0, 8'hFF, 32'h11111111, 1, 1, i % 8, 1);
    // Weighted pair 0 (w=3) and 2 (w=2)
    add(1, 8'h05, 32'h00000203, 1, 0, 0, 0);
    add(0, 8'h05, 32'h00000203, 1, 1, 0, 3);
    add(0, 8'h05, 32'h00000203, 1, 1, 0, 2);
    add(0, 8'h05, 32'h00000203, 1, 1, 0, 1);
    add(0, 8'h05, 32'h00000203, 1, 1, 2, 2);
    add(0, 8'h05, 32'h00000203, 1, 1, 2, 1);
    add(0, 8'h05, 32'h00000203, 1, 1, 0, 3);
    // Lone requester 3 with weight 0
    add(1, 8'h08, 32'h00000000, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 8'h08, 32'h00000000, 1, 1, 3, 1);
    // Grant to 4 (w=5), request dropped with ack same cycle while 6 waits (w=7)
    add(1, 8'h10, 32'h07050000, 0, 0, 0, 0);
    add(0, 8'h10, 32'h07050000, 0, 1, 4, 5);
    add(0, 8'h40, 32'h07050000, 1, 1, 6, 7);
    add(0, 8'h40, 32'h07050000, 1, 1, 6, 6);
    // Reset mid-grant on 5, then full request restarts at 0
    add(1, 8'h20, 32'h00200001, 0, 0, 0, 0);
    add(0, 8'h20, 32'h00200001, 0, 1, 5, 2);
    add(1, 8'h20, 32'h00200001, 0, 0, 0, 0);
    add(0, 8'hFF, 32'h00200001, 0, 1, 0, 1);
    // Idle after a grant keeps the index, clears credit
    add(1, 8'h20, 32'h00300000, 1, 0, 0, 0);
    add(0, 8'h20, 32'h00300000, 1, 1, 5, 3);
    add(0, 8'h00, 32'h00300000, 1, 0, 5, 0);
    // No requests, ack toggling
    add(1, 8'h00, 32'hFFFFFFFF, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 32'hFFFFFFFF, logic'(i % 2 == 0), 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].w, vecs[i].ack);
      tick();
      check($sformatf("vec%0d_valid", i),  int'(o_grant_valid), vecs[i].ev);
      check($sformatf("vec%0d_grant", i),  int'(o_grant),       vecs[i].eg);
      check($sformatf("vec%0d_credit", i), int'(o_credit),      vecs[i].ec);
    end

    // Weight change mid-grant only takes effect at the next load
    drive(1'b1, 8'h02, 32'h00000030, 1'b0);
    tick();
    drive(1'b0, 8'h02, 32'h00000030, 1'b0);
    tick();
    check("wchg_load", int'(o_credit), 3);
    drive(1'b0, 8'h02, 32'h00000090, 1'b1);
    tick();
    check("wchg_hold1", int'(o_credit), 2);
    tick();
    check("wchg_hold2", int'(o_credit), 1);
    tick();
    check("wchg_reload", int'(o_credit), 9);
    check("wchg_grant",  int'(o_grant), 1);

    // Randomized run against the model
    drive(1'b1, 8'h00, 32'h0, 1'b0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0:       req = 8'h00;
        1:       req = 8'(1 << $urandom_range(0, 7));
        default: req = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) wt = $urandom;
      ack = ($urandom_range(0, 2) != 0);
      tick();
      check("rand_valid",  int'(o_grant_valid), m_valid);
      check("rand_grant",  int'(o_grant),       m_grant);
      check("rand_credit", int'(o_credit),      m_credit);
      check("rand_credit_nonzero", int'(o_credit != 4'd0), int'(o_grant_valid));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/weighted_round_robin.md
WEIGHTED_ROUND_ROBIN -- requirements
Module: weighted_round_robin

Interface
REQ-001 SHALL provide parameter REQUEST_WIDTH, default 8, giving the number of requesters (at least 2).
REQ-002 SHALL provide parameter WEIGHT_WIDTH, default 4, giving the width of each per-requester weight.
REQ-003 SHALL provide port i_clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL provide port i_rst, input, 1, reset: synchronous and active-high.
REQ-005 SHALL provide port i_request, input, REQUEST_WIDTH, where bit i high means requester i wants the resource.
REQ-006 SHALL provide port i_weight, input, REQUEST_WIDTH x WEIGHT_WIDTH, packed, giving the transfer count per grant for each requester.
REQ-007 SHALL provide port i_ack, input, 1, meaning one transfer of the current grantee completes this cycle.
REQ-008 SHALL provide port o_grant_valid, input-free output, 1, high while a grant is held.
REQ-009 SHALL provide port o_grant, output, clog2(REQUEST_WIDTH), the index of the current grantee.
REQ-010 SHALL provide port o_credit, output, WEIGHT_WIDTH, the transfers remaining in the current grant.

Function
REQ-011 SHALL register all outputs, with no combinational path from any input to any output.
REQ-012 SHALL hold a rotation pointer P equal to the last granted index; the search order is P+1, P+2, ... wrapping modulo REQUEST_WIDTH, so P itself is searched last.
REQ-013 SHALL define release = o_grant_valid && ((i_ack && o_credit==1) || !i_request[o_grant]).
REQ-014 SHALL arbitrate in any cycle where o_grant_valid==0 or release==1.
REQ-015 SHALL select the winner as the first set i_request bit in the search order when it arbitrates.
REQ-016 SHALL, on a winner W, set next-cycle o_grant_valid=1, o_grant=W, P=W and o_credit=i_weight[W], with weight 0 loaded as 1.
REQ-017 SHALL, on arbitration with no request set, set o_grant_valid=0 and hold o_grant, P and o_credit=0.
REQ-018 SHALL produce one cycle of latency from a request in the idle state to o_grant_valid.
REQ-019 SHALL produce no bubble on handover: the release cycle is also the arbitration cycle, and the new grant appears the next cycle.
REQ-020 SHALL decrement o_credit by 1 when o_grant_valid && i_ack && !release.
REQ-021 SHALL re-grant the same requester after credit exhaustion, with a fresh credit, when it is the only requester.
REQ-022 SHALL ignore i_ack while o_grant_valid==0.
REQ-023 SHALL treat an i_ack in the same cycle that i_request[o_grant] falls as release, without decrementing o_credit.
REQ-024 SHALL sample i_weight only at grant load; weight changes during a grant have no effect on it.
REQ-025 SHALL never let o_credit underflow; it is 0 only while o_grant_valid==0.

Reset
REQ-026 SHALL, when i_rst is high at a rising edge, set o_grant_valid=0, o_grant=0, o_credit=0 and P=REQUEST_WIDTH-1, so that index 0 is searched first.
REQ-027 SHALL apply reset asserted mid-grant on that edge, discarding the credit, with no arbitration in that cycle.
REQ-028 SHALL allow arbitration to resume in the first cycle with i_rst low.

Verification
REQ-029 SHALL cover: after reset, i_request=8'hFF, all weights 1, i_ack held 1 -> o_grant sequence 0,1,...,7,0 on consecutive cycles with o_grant_valid continuously high.
REQ-030 SHALL cover: i_request=8'h05, i_weight[0]=3, i_weight[2]=2, i_ack=1 -> o_grant 0,0,0,2,2,0 with o_credit 3,2,1,2,1,3.
REQ-031 SHALL cover: requester 3 alone with weight 0 -> o_credit=1, and re-grant of 3 every ack cycle.
REQ-032 SHALL cover: a grant to 4 with credit 5, then i_request[4] dropped while 6 requests -> the next cycle gives o_grant=6 and o_credit=i_weight[6].
REQ-033 SHALL cover: i_rst pulsed while o_grant=5 and o_credit=2 -> the next cycle gives o_grant_valid=0, o_grant=0 and o_credit=0; the following grant with i_request=8'hFF is to 0.
REQ-034 SHALL cover: i_request=0 with i_ack toggling -> o_grant_valid stays 0 and o_credit stays 0.
